page_buffer: RTL
================

PAGE_BUFFER -- requirements
Module: page_buffer

Interface
REQ-001 Parameter DataWidth, default 16, sets the word width of every data port.
REQ-002 Parameter Depth, default 2048, sets the number of words in one page.
REQ-003 Parameter AddrWidth, default 11, sets the pointer width; it SHALL equal clog2(Depth).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 buf_sel  input  1  host-side port select.
REQ-007 buf_we  input  1  host write strobe.
REQ-008 buf_re  input  1  host read strobe.
REQ-009 buf_in  input  DataWidth  host write data.
REQ-010 buf_out  output  DataWidth  host read data.
REQ-011 cntrl_sel  input  1  controller-side port select.
REQ-012 cntrl_we  input  1  controller write strobe.
REQ-013 cntrl_re  input  1  controller read strobe.
REQ-014 cntrl_in  input  DataWidth  controller write data.
REQ-015 cntrl_out  output  DataWidth  controller read data.
REQ-016 host_buf_status  output  1  set when a host-written page is complete and waiting for the controller.
REQ-017 buf_cntrl_status  output  1  set when a controller-written page is complete and waiting for the host.

Function
REQ-018 The block SHALL hold one page of Depth words, with separate write pointer wptr and read pointer rptr, each AddrWidth+1 bits wide.
REQ-019 The FSM SHALL have states EMPTY, H_WR, H_FULL, C_RD, C_WR, C_FULL and H_RD.
REQ-020 Host write beat: buf_sel & buf_we & !buf_re in EMPTY or H_WR SHALL store buf_in at mem[wptr] and increment wptr; the first beat moves EMPTY to H_WR.
REQ-021 The beat with wptr == Depth-1 SHALL move the FSM to H_FULL, clear wptr, and set host_buf_status on the following edge.
REQ-022 Controller read beat: cntrl_sel & cntrl_re & !cntrl_we in H_FULL or C_RD SHALL register mem[rptr] to cntrl_out on that edge, giving 1-cycle latency, and increment rptr.
REQ-023 The read beat with rptr == Depth-1 SHALL move the FSM to EMPTY, clear rptr and clear host_buf_status on the same edge.
REQ-024 Controller write beats from EMPTY or C_WR (cntrl_sel & cntrl_we & !cntrl_re) SHALL mirror REQ-020/021 and end in C_FULL with buf_cntrl_status set.
REQ-025 Host read beats from C_FULL or H_RD (buf_sel & buf_re & !buf_we) SHALL mirror REQ-022/023 on buf_out and end in EMPTY with buf_cntrl_status cleared.
REQ-026 A beat outside its legal states SHALL be ignored: no memory write, no pointer change, no state change.
REQ-027 A port with re and we high together SHALL be treated as idle.
REQ-028 In EMPTY with simultaneous host and controller write beats, the host SHALL win and the controller beat SHALL be dropped.
REQ-029 Deasserting sel or the strobe mid-transfer SHALL pause the transfer; pointers and state hold, and the transfer resumes at the next beat.
REQ-030 buf_out and cntrl_out SHALL hold their last value when not reading.
REQ-031 host_buf_status and buf_cntrl_status SHALL never be 1 simultaneously.

Reset
REQ-032 On rst=1 at a clock edge: state EMPTY; wptr and rptr 0; buf_out and cntrl_out 0; both status outputs 0. Memory contents are don't-care.
REQ-033 Reset asserted mid-transfer SHALL abort the page; no status flag is set afterwards until a full new page is written.

Verification
REQ-034 Host writes the words 0..2047 on consecutive beats -> host_buf_status=1 one cycle after the final beat; the FSM is in H_FULL.
REQ-035 Controller reads 2048 beats after REQ-034 -> cntrl_out shows 0,1,...,2047, each one cycle after its beat; host_buf_status=0 after the last beat.
REQ-036 Controller writes 16'hA5A5^i for i=0..2047, then the host reads the page -> buf_out matches; buf_cntrl_status goes 1 then 0.
REQ-037 Host and controller issue write beats in the same EMPTY cycle -> only the host data is stored (mem[0]=buf_in); the controller is then ignored until the page drains.
REQ-038 buf_sel drops for 5 cycles after beat 100, then resumes -> the page is stored contiguously and completes normally.
REQ-039 rst pulsed after 1000 host beats -> all outputs 0; a fresh 2048-beat write is required before host_buf_status rises.

Source files
------------

// File: rtl/page_buffer.sv
// Single-page ping-pong style buffer shared between a host port and a controller port.
// One side fills the whole page, the other side drains it, then the page is free again.
module page_buffer #(
  parameter int DataWidth = 16,
  parameter int Depth     = 2048,
  parameter int AddrWidth = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 buf_sel,
  input  logic                 buf_we,
  input  logic                 buf_re,
  input  logic [DataWidth-1:0] buf_in,
  output logic [DataWidth-1:0] buf_out,
  input  logic                 cntrl_sel,
  input  logic                 cntrl_we,
  input  logic                 cntrl_re,
  input  logic [DataWidth-1:0] cntrl_in,
  output logic [DataWidth-1:0] cntrl_out,
  output logic                 host_buf_status,
  output logic                 buf_cntrl_status
);

  localparam logic [2:0] EMPTY  = 3'd0;
  localparam logic [2:0] H_WR   = 3'd1;
  localparam logic [2:0] H_FULL = 3'd2;
  localparam logic [2:0] C_RD   = 3'd3;
  localparam logic [2:0] C_WR   = 3'd4;
  localparam logic [2:0] C_FULL = 3'd5;
  localparam logic [2:0] H_RD   = 3'd6;

  localparam logic [AddrWidth:0] LastPtr = (AddrWidth+1)'(Depth - 1);

  logic [2:0]           state;
  logic [AddrWidth:0]   wptr;
  logic [AddrWidth:0]   rptr;
  logic [DataWidth-1:0] mem [Depth];

  logic h_wr_beat, h_rd_beat, c_wr_beat, c_rd_beat;
  logic h_wr_ok, h_rd_ok, c_wr_ok, c_rd_ok;
  logic wr_en, wr_last, rd_last;
  logic [DataWidth-1:0] wr_data;

  // re and we together decode to no beat at all, so such a port is idle.
  assign h_wr_beat = buf_sel & buf_we & ~buf_re;
  assign h_rd_beat = buf_sel & buf_re & ~buf_we;
  assign c_wr_beat = cntrl_sel & cntrl_we & ~cntrl_re;
  assign c_rd_beat = cntrl_sel & cntrl_re & ~cntrl_we;

  // Host has priority when both sides try to claim an empty page.
  assign h_wr_ok = h_wr_beat & ((state == EMPTY) | (state == H_WR));
  assign c_wr_ok = c_wr_beat & (((state == EMPTY) & ~h_wr_beat) | (state == C_WR));
  assign c_rd_ok = c_rd_beat & ((state == H_FULL) | (state == C_RD));
  assign h_rd_ok = h_rd_beat & ((state == C_FULL) | (state == H_RD));

  assign wr_en   = h_wr_ok | c_wr_ok;
  assign wr_data = h_wr_ok ? buf_in : cntrl_in;
  assign wr_last = (wptr == LastPtr);
  assign rd_last = (rptr == LastPtr);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr[AddrWidth-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= EMPTY;
      wptr             <= '0;
      rptr             <= '0;
      buf_out          <= '0;
      cntrl_out        <= '0;
      host_buf_status  <= 1'b0;
      buf_cntrl_status <= 1'b0;
    end else begin
      if (wr_en) begin
        if (wr_last) begin
          wptr             <= '0;
          state            <= h_wr_ok ? H_FULL : C_FULL;
          host_buf_status  <= h_wr_ok;
          buf_cntrl_status <= c_wr_ok;
        end else begin
          wptr  <= wptr + 1'b1;
          state <= h_wr_ok ? H_WR : C_WR;
        end
      end
      if (c_rd_ok) begin
        cntrl_out <= mem[rptr[AddrWidth-1:0]];
        if (rd_last) begin
          rptr            <= '0;
          state           <= EMPTY;
          host_buf_status <= 1'b0;
        end else begin
          rptr  <= rptr + 1'b1;
          state <= C_RD;
        end
      end
      if (h_rd_ok) begin
        buf_out <= mem[rptr[AddrWidth-1:0]];
        if (rd_last) begin
          rptr             <= '0;
          state            <= EMPTY;
          buf_cntrl_status <= 1'b0;
        end else begin
          rptr  <= rptr + 1'b1;
          state <= H_RD;
        end
      end
    end
  end

endmodule
